fifo_sample_reader: RTL and testbench

//  Downstream consumer of the 8-bit audio byte FIFO. Paced by an internal sample-rate

---
 rtl/fifo_sample_reader.sv | 87 ++++++++
 tb/tb_fifo_sample_reader.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_sample_reader.sv
// fifo_sample_reader: pops LSB/MSB byte pairs from the audio FIFO on a sample-rate tick and emits signed 16-bit samples, substituting a fallback sample on underflow
module fifo_sample_reader #(
  parameter int TICK_DIV       = 2267,
  parameter bit UNDERFLOW_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [7:0]  fifo_data,
  input  logic        fifo_empty,
  output logic        fifo_rd,
  output logic [15:0] sample_out,
  output logic        sample_valid,
  output logic        underflow,
  output logic [15:0] underflow_cnt
);
  localparam int CW = $clog2(TICK_DIV);
  typedef enum logic [1:0] {IDLE, GET_LO, GET_HI, OUT} state_t;
  state_t         state;
  logic [CW-1:0]  cnt;
  logic           pending;
  logic [7:0]     lo;
  logic [15:0]    last;
  logic           tick;
  logic           reading;
  logic           fallback;
  assign tick     = en && (cnt == CW'(TICK_DIV - 1));
  assign reading  = (state == GET_LO) || (state == GET_HI);
  assign fifo_rd  = reading && !fifo_empty && en;
  // a period ends while a sample is still incomplete: substitute the fallback
  assign fallback = tick && reading && !fifo_rd;
  // sample-period counter, held at zero while disabled
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= (!en || tick) ? '0 : cnt + CW'(1);
  // byte assembly FSM; ticks arriving while busy are remembered in pending
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state         <= IDLE;
      pending       <= 1'b0;
      lo            <= '0;
      last          <= '0;
      sample_out    <= '0;
      sample_valid  <= 1'b0;
      underflow     <= 1'b0;
      underflow_cnt <= '0;
    end else begin
      sample_valid <= 1'b0;
      underflow    <= 1'b0;
      if (!en) begin
        state   <= IDLE;
        pending <= 1'b0;
      end else begin
        if (fallback) begin
          sample_out   <= UNDERFLOW_ZERO ? 16'h0000 : last;
          sample_valid <= 1'b1;
          underflow    <= 1'b1;
          if (underflow_cnt != 16'hFFFF) underflow_cnt <= underflow_cnt + 16'd1;
        end
        case (state)
          IDLE:
            if (tick || pending) begin
              state   <= GET_LO;
              pending <= 1'b0;
            end
          GET_LO:
            if (fifo_rd) begin
              lo      <= fifo_data;
              state   <= GET_HI;
              pending <= pending | tick;
            end
          GET_HI:
            if (fifo_rd) begin
              sample_out   <= {fifo_data, lo};
              last         <= {fifo_data, lo};
              sample_valid <= 1'b1;
              state        <= OUT;
              pending      <= pending | tick;
            end
          OUT: begin
            state   <= pending ? GET_LO : IDLE;
            pending <= tick;
          end
        endcase
      end
    end
endmodule

// File: tb/tb_fifo_sample_reader.sv
// tb_fifo_sample_reader: directed scoreboard bench for fifo_sample_reader in both fallback modes
module tb_fifo_sample_reader;
  localparam int TD = 8;
  typedef struct {logic [15:0] v; logic uf;} exp_t;
  logic        clk = 1'b0;
  logic        rst_n, en;
  logic [7:0]  fd0 = 8'h00, fd1 = 8'h00;
  logic        fe0 = 1'b1, fe1 = 1'b1;
  logic        rd0, rd1, sv0, sv1, uf0, uf1;
  logic [15:0] so0, so1, uc0, uc1;
  logic [7:0]  inb0[$], inb1[$], fq0[$], fq1[$];
  exp_t        q0[$], q1[$];
  exp_t        e0, e1;
  int          checks = 0, errors = 0, cyc = 0, uf_seen0 = 0, rd_cnt0 = 0;
  int          t0, t1, first_rd, v1, v2, rdc;

  fifo_sample_reader #(.TICK_DIV(TD), .UNDERFLOW_ZERO(1'b1)) u0 (
    .clk(clk), .rst_n(rst_n), .en(en), .fifo_data(fd0), .fifo_empty(fe0), .fifo_rd(rd0),
    .sample_out(so0), .sample_valid(sv0), .underflow(uf0), .underflow_cnt(uc0));
  fifo_sample_reader #(.TICK_DIV(TD), .UNDERFLOW_ZERO(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n), .en(en), .fifo_data(fd1), .fifo_empty(fe1), .fifo_rd(rd1),
    .sample_out(so1), .sample_valid(sv1), .underflow(uf1), .underflow_cnt(uc1));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    inb0.push_back(b);
    inb1.push_back(b);
  endtask

  task automatic expect_s(input logic [15:0] a, input logic [15:0] b, input logic u);
    q0.push_back('{v: a, uf: u});
    q1.push_back('{v: b, uf: u});
  endtask

  task automatic wait_uf(input int n, input int lim);
    for (int i = 0; i < lim && uf_seen0 < n; i++) @(negedge clk);
    chk("wait_underflows", uf_seen0, n);
  endtask

  task automatic wait_drain(input int lim);
    for (int i = 0; i < lim && (q0.size() + q1.size()) != 0; i++) @(negedge clk);
    chk("scoreboard_drained", q0.size() + q1.size(), 0);
  endtask

  task automatic wait_rel(input int base, input int r);
    for (int i = 0; i < 200 && (cyc - base) < r; i++) @(negedge clk);
    chk("reached_cycle", cyc - base, r);
  endtask

  // FIFO model: writes land after the next edge, the head byte is popped on fifo_rd
  always @(posedge clk) begin
    cyc++;
    if (rd0) void'(fq0.pop_front());
    if (rd1) void'(fq1.pop_front());
    while (inb0.size() != 0) fq0.push_back(inb0.pop_front());
    while (inb1.size() != 0) fq1.push_back(inb1.pop_front());
    fe0 <= (fq0.size() == 0);
    fe1 <= (fq1.size() == 0);
    fd0 <= (fq0.size() != 0) ? fq0[0] : 8'h00;
    fd1 <= (fq1.size() != 0) ? fq1[0] : 8'h00;
  end

  // output monitor: every sample_valid pulse is matched against the scoreboard
  always @(negedge clk) begin
    if (rd0) begin
      rd_cnt0++;
      chk("rd_when_empty0", fe0, 0);
    end
    if (rd1) chk("rd_when_empty1", fe1, 0);
    if (uf0) uf_seen0++;
    if (sv0) begin
      if (q0.size() == 0) chk("unexpected_valid0", q0.size(), 1);
      else begin
        e0 = q0.pop_front();
        chk("sample0", so0, e0.v);
        chk("underflow0", uf0, e0.uf);
      end
    end else if (uf0) chk("underflow_without_valid0", sv0, 1);
    if (sv1) begin
      if (q1.size() == 0) chk("unexpected_valid1", q1.size(), 1);
      else begin
        e1 = q1.pop_front();
        chk("sample1", so1, e1.v);
        chk("underflow1", uf1, e1.uf);
      end
    end else if (uf1) chk("underflow_without_valid1", sv1, 1);
  end

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_sample0", so0, 0);
    chk("rst_valid0", sv0, 0);
    chk("rst_underflow0", uf0, 0);
    chk("rst_cnt0", uc0, 0);
    chk("rst_rd0", rd0, 0);
    chk("rst_sample1", so1, 0);
    rst_n = 1'b1;
    @(negedge clk);
    // basic pair: LSB then MSB
    push(8'h34);
    push(8'h12);
    expect_s(16'h1234, 16'h1234, 1'b0);
    @(negedge clk);
    en = 1'b1;
    t0 = cyc;
    first_rd = -1;
    for (int i = 0; i < 40 && !sv0; i++) begin
      @(negedge clk);
      if (rd0 && first_rd < 0) first_rd = cyc - t0;
    end
    chk("t1_first_rd", first_rd, TD);
    chk("t1_valid_latency", cyc - t0, TD + 2);
    chk("t1_cnt", uc0, 0);
    // empty FIFO: three fallbacks, no pops
    rdc = rd_cnt0;
    repeat (3) expect_s(16'h0000, 16'h1234, 1'b1);
    wait_uf(3, 60);
    chk("t2_cnt0", uc0, 3);
    chk("t2_cnt1", uc1, 3);
    chk("t2_no_rd", rd_cnt0, rdc);
    // partial sample: fallback keeps lo byte so alignment survives
    push(8'hCD);
    push(8'hAB);
    push(8'hEF);
    expect_s(16'hABCD, 16'hABCD, 1'b0);
    expect_s(16'h0000, 16'hABCD, 1'b1);
    wait_uf(4, 40);
    push(8'h01);
    expect_s(16'h01EF, 16'h01EF, 1'b0);
    wait_drain(20);
    chk("t3_cnt1", uc1, 4);
    // MSB pop on the tick cycle, then back-to-back sample without waiting a period
    wait_rel(t0, 64);
    push(8'h22);
    wait_rel(t0, 70);
    push(8'h11);
    push(8'h44);
    push(8'h33);
    expect_s(16'h1122, 16'h1122, 1'b0);
    expect_s(16'h3344, 16'h3344, 1'b0);
    v1 = -1;
    v2 = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (sv0) begin
        if (v1 < 0) v1 = cyc - t0;
        else if (v2 < 0) v2 = cyc - t0;
      end
    end
    chk("t4_hi_on_tick", v1, 72);
    chk("t4_back_to_back", v2, 75);
    chk("t4_no_underflow", uc0, 4);
    // disable mid-sample: partial lo discarded, queued bytes untouched
    push(8'h99);
    push(8'h78);
    push(8'h56);
    wait_rel(t0, 84);
    chk("t5_rd_before_drop", rd0, 1);
    en = 1'b0;
    #1;
    chk("t5_rd_drop", rd0, 0);
    @(negedge clk);
    chk("t5_hold_sample", so0, 16'h3344);
    chk("t5_hold_cnt", uc0, 4);
    chk("t5_no_valid", sv0, 0);
    @(negedge clk);
    expect_s(16'h5678, 16'h5678, 1'b0);
    en = 1'b1;
    t1 = cyc;
    first_rd = -1;
    for (int i = 0; i < 40 && !sv0; i++) begin
      @(negedge clk);
      if (rd0 && first_rd < 0) first_rd = cyc - t1;
    end
    chk("t5_first_rd", first_rd, TD);
    chk("t5_valid_latency", cyc - t1, TD + 2);
    wait_drain(5);
    // saturation of the underflow counter
    force u0.underflow_cnt = 16'hFFFE;
    force u1.underflow_cnt = 16'hFFFE;
    @(negedge clk);
    release u0.underflow_cnt;
    release u1.underflow_cnt;
    @(negedge clk);
    chk("t6_forced", uc0, 16'hFFFE);
    repeat (3) expect_s(16'h0000, 16'h5678, 1'b1);
    wait_uf(7, 60);
    chk("t6_sat0", uc0, 16'hFFFF);
    chk("t6_sat1", uc1, 16'hFFFF);
    wait_drain(5);
    en = 1'b0;
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
